// File: rtl/m_fb_pkg.sv
// rtl/m_fb_pkg.sv - framebuffer writer shared geometry, widths and state encoding
package m_fb_pkg;

  localparam int SCR_W   = 160;
  localparam int SCR_H   = 120;
  localparam int FB_SIZE = SCR_W * SCR_H;
  localparam int FB_AW   = 15;
  localparam int COLOR_W = 12;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } fb_state_e;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
  } px_entry_t;

  localparam int PX_ENTRY_W = $bits(px_entry_t);

endpackage

// File: rtl/m_px_fifo.sv
// rtl/m_px_fifo.sv - synchronous pixel FIFO with full/empty flags and occupancy count
module m_px_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 27
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/m_fb_writer.sv
// rtl/m_fb_writer.sv - queued pixel writer and screen clear onto a shared framebuffer port
module m_fb_writer
  import m_fb_pkg::*;
#(
  parameter int SCR_W      = m_fb_pkg::SCR_W,
  parameter int SCR_H      = m_fb_pkg::SCR_H,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               px_valid,
  output logic               px_ready,
  input  logic [X_W-1:0]     px_x,
  input  logic [Y_W-1:0]     px_y,
  input  logic [COLOR_W-1:0] px_color,
  input  logic               clr_req,
  input  logic [COLOR_W-1:0] clr_color,
  output logic               clr_busy,
  input  logic               mem_busy,
  output logic [FB_AW-1:0]   fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               fb_wren,
  output logic [7:0]         drop_count
);

  localparam int CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int FB_SIZE_P = SCR_W * SCR_H;

  fb_state_e          state;
  fb_state_e          state_next;
  px_entry_t          in_entry;
  px_entry_t          head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_empty_next;
  logic               px_accept;
  logic               px_in_range;
  logic               clr_start;
  logic               clr_last;
  logic [COLOR_W-1:0] clr_color_q;
  logic [FB_AW-1:0]   clr_addr;
  logic               wr_en;
  logic [FB_AW-1:0]   wr_addr;
  logic [COLOR_W-1:0] wr_data;

  assign px_ready    = !fifo_full && (state == ST_IDLE);
  assign clr_busy    = (state != ST_IDLE);
  assign px_accept   = px_valid && px_ready;
  assign px_in_range = (32'(px_x) < SCR_W) && (32'(px_y) < SCR_H);
  assign fifo_push   = px_accept && px_in_range;
  assign clr_start   = (state == ST_IDLE) && clr_req;
  assign clr_last    = (clr_addr == FB_AW'(FB_SIZE_P - 1));
  assign in_entry    = '{x: px_x, y: px_y, color: px_color};

  // A pixel accepted alongside clr_req lands in the FIFO, so it decides DRAIN vs CLEAR.
  assign fifo_empty_next = !fifo_push && (fifo_empty || (fifo_pop && fifo_count == CW'(1)));

  m_px_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PX_ENTRY_W)
  ) u_px_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (in_entry),
    .pop       (fifo_pop),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (clr_req) state_next = fifo_empty_next ? ST_CLEAR : ST_DRAIN;
      ST_DRAIN: if (fifo_pop && fifo_count == CW'(1)) state_next = ST_CLEAR;
      ST_CLEAR: if (wr_en && clr_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = clr_addr;
    wr_data  = clr_color_q;
    case (state)
      ST_IDLE, ST_DRAIN: begin
        if (!fifo_empty && !mem_busy) begin
          fifo_pop = 1'b1;
          wr_en    = 1'b1;
          wr_addr  = FB_AW'(32'(head.y) * SCR_W + 32'(head.x));
          wr_data  = head.color;
        end
      end
      ST_CLEAR: wr_en = !mem_busy;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fb_wren <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_wren <= wr_en;
      if (wr_en) begin
        fb_addr <= wr_addr;
        fb_data <= wr_data;
      end
    end
  end

  // Clear address only advances on granted edges, so mem_busy simply holds it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clr_color_q <= '0;
      clr_addr    <= '0;
    end else if (clr_start) begin
      clr_color_q <= clr_color;
      clr_addr    <= '0;
    end else if (state == ST_CLEAR && wr_en) begin
      clr_addr <= clr_last ? '0 : clr_addr + FB_AW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (px_accept && !px_in_range && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_m_fb_writer.sv
// tb/tb_m_fb_writer.sv - randomized bench for m_fb_writer against an ordered write-stream model
module tb_m_fb_writer;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int DEPTH = 4;
  localparam int FBS   = W * H;

  logic        clock;
  logic        reset;
  logic        px_valid;
  logic        px_ready;
  logic [7:0]  px_x;
  logic [6:0]  px_y;
  logic [11:0] px_color;
  logic        clr_req;
  logic [11:0] clr_color;
  logic        clr_busy;
  logic        mem_busy;
  logic [14:0] fb_addr;
  logic [11:0] fb_data;
  logic        fb_wren;
  logic [7:0]  drop_count;

  m_fb_writer #(
    .SCR_W      (W),
    .SCR_H      (H),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .px_x       (px_x),
    .px_y       (px_y),
    .px_color   (px_color),
    .clr_req    (clr_req),
    .clr_color  (clr_color),
    .clr_busy   (clr_busy),
    .mem_busy   (mem_busy),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_wren    (fb_wren),
    .drop_count (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int addr;
    int data;
    bit is_clr;
  } wr_t;

  wr_t exp_q[$];
  int  pend_px;
  int  exp_drop;
  bit  m_busy;
  bit  elig_q;
  bit  mb_q;
  bit  hit_5000;
  bit  last_acc;
  int  n_checks;
  int  n_fail;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: every accepted in-range pixel and every pixel of a clear is one entry in
  // an ordered write stream; an entry may leave on any edge after it was queued.
  task automatic observe();
    wr_t e;
    bit  exp_ready;
    expect_eq("wren", fb_wren, elig_q && !mb_q);
    if (fb_wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        expect_eq("write_unexpected", fb_wren, 0);
      end else begin
        e = exp_q.pop_front();
        expect_eq("addr", fb_addr, e.addr);
        expect_eq("data", fb_data, e.data);
        if (!e.is_clr) pend_px--;
        else begin
          if (e.addr == 5000) hit_5000 = 1'b1;
          if (e.addr == FBS - 1) m_busy = 1'b0;
        end
      end
    end
    expect_eq("clr_busy", clr_busy, m_busy);
    exp_ready = !m_busy && (pend_px < DEPTH);
    expect_eq("px_ready", px_ready, exp_ready);
    expect_eq("drop_count", drop_count, exp_drop);

    elig_q   = (exp_q.size() > 0);
    mb_q     = mem_busy;
    last_acc = px_valid && exp_ready;
    if (last_acc) begin
      if (int'(px_x) < W && int'(px_y) < H) begin
        exp_q.push_back('{int'(px_y) * W + int'(px_x), int'(px_color), 1'b0});
        pend_px++;
      end else if (exp_drop < 255) begin
        exp_drop++;
      end
    end
    if (clr_req && !m_busy) begin
      m_busy = 1'b1;
      for (int a = 0; a < FBS; a++) exp_q.push_back('{a, int'(clr_color), 1'b1});
    end
  endtask

  task automatic step(input bit v, input int x, input int y, input int c,
                      input bit clr, input int cc, input bit mb);
    @(posedge clock);
    #1;
    px_valid  = v;
    px_x      = 8'(x);
    px_y      = 7'(y);
    px_color  = 12'(c);
    clr_req   = clr;
    clr_color = 12'(cc);
    mem_busy  = mb;
    @(negedge clock);
    observe();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend_px  = 0;
    exp_drop = 0;
    m_busy   = 1'b0;
    elig_q   = 1'b0;
    mb_q     = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    n_checks = 0;
    n_fail   = 0;
    hit_5000 = 1'b0;
    last_acc = 1'b0;
    model_reset();
    reset     = 1'b1;
    px_valid  = 1'b0;
    px_x      = '0;
    px_y      = '0;
    px_color  = '0;
    clr_req   = 1'b0;
    clr_color = '0;
    mem_busy  = 1'b0;
    repeat (3) @(negedge clock);
    expect_eq("rst_wren", fb_wren, 0);
    expect_eq("rst_addr", fb_addr, 0);
    expect_eq("rst_data", fb_data, 0);
    expect_eq("rst_clr_busy", clr_busy, 0);
    expect_eq("rst_drop", drop_count, 0);
    expect_eq("rst_ready", px_ready, 1);
    reset = 1'b0;

    // Single pixel: write visible two cycles after acceptance.
    step(1, 10, 5, 'h0F0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    expect_eq("single_wren", fb_wren, 1);
    expect_eq("single_addr", fb_addr, 810);
    expect_eq("single_data", fb_data, 'h0F0);
    idle(3);

    // Five pixels against a stalled port, then release.
    acc = 0;
    for (int t = 0; t < 40 && acc < 5; t++) begin
      step(1, 20 + acc * 31, 3 + acc * 23, $urandom_range(0, 4095), 0, 0, t < 8);
      if (last_acc) acc++;
    end
    expect_eq("burst_accepted", acc, 5);
    idle(8);

    // Out-of-range pixels, including both edges, saturate drop_count.
    step(1, 160, 0, 'hABC, 0, 0, 0);
    step(1, 0, 120, 'hABC, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) step(1, $urandom_range(160, 255), $urandom_range(0, 127), $urandom, 0, 0, $urandom % 2);
      else            step(1, $urandom_range(0, 255), $urandom_range(120, 127), $urandom, 0, 0, $urandom % 2);
    end
    idle(3);
    expect_eq("drop_saturated", drop_count, 255);

    // Mixed random traffic, corner coordinates included.
    step(1, 159, 119, 'hFFF, 0, 0, 0);
    step(1, 0, 0, 'h123, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom % 4 != 0, $urandom_range(0, 175), $urandom_range(0, 127), $urandom,
           0, 0, $urandom % 3 == 0);
    idle(10);

    // Full clear with the port always free.
    step(0, 0, 0, 0, 1, 'h00F, 0);
    for (int t = 0; t < FBS + 50 && m_busy; t++) step(0, 0, 0, 0, 0, 0, 0);
    idle(2);
    expect_eq("clear0_done", clr_busy, 0);

    // Clear under 50% port contention, with refused pixels and ignored clr_req.
    step(0, 0, 0, 0, 1, $urandom_range(0, 4095), $urandom % 2);
    for (int t = 0; t < 3 * FBS && m_busy; t++)
      step($urandom % 2, $urandom_range(0, 175), $urandom_range(0, 127), $urandom,
           (t < 1000) && ($urandom % 64 == 0), $urandom, $urandom % 2);
    idle(5);
    expect_eq("clear1_done", clr_busy, 0);

    // Queued pixels ahead of a clear, then reset partway through it.
    hit_5000 = 1'b0;
    for (int i = 0; i < 3; i++) step(1, 40 + i, 60 + i, $urandom, 0, 0, 1);
    step(0, 0, 0, 0, 1, 'h5A5, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 1, $urandom, 0, 0, 1);
    for (int t = 0; t < 3 * FBS && !hit_5000; t++)
      step($urandom % 2, $urandom_range(0, 159), $urandom_range(0, 119), $urandom, 0, 0, $urandom % 2);
    expect_eq("reached_5000", hit_5000, 1);

    px_valid = 1'b0;
    clr_req  = 1'b0;
    mem_busy = 1'b0;
    #1 reset = 1'b1;
    #1;
    expect_eq("abort_wren", fb_wren, 0);
    expect_eq("abort_clr_busy", clr_busy, 0);
    expect_eq("abort_ready", px_ready, 1);
    expect_eq("abort_addr", fb_addr, 0);
    model_reset();
    #1 reset = 1'b0;
    idle(20);
    expect_eq("post_abort_drop", drop_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/m_fb_writer.md
M_FB_WRITER -- requirements
Module: m_fb_writer

Interface
REQ-001 Parameters SHALL be: SCR_W, 160, screen width in pixels; SCR_H, 120, screen height in pixels; FIFO_DEPTH, 4, pixel FIFO entries (power of two).
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous active-high reset
px_valid  in  1  pixel write request
px_ready  out  1  pixel write accepted when high with px_valid
px_x  in  8  pixel x
px_y  in  7  pixel y
px_color  in  12  pixel colour, R/G/B 4 bits each
clr_req  in  1  single-cycle clear-screen request
clr_color  in  12  fill colour, sampled with clr_req
clr_busy  out  1  clear pending or in progress
mem_busy  in  1  scanout owns framebuffer port this cycle; no write allowed
fb_addr  out  15  framebuffer write address
fb_data  out  12  framebuffer write data
fb_wren  out  1  framebuffer write strobe
drop_count  out  8  saturating count of out-of-range pixels

Function
REQ-004 A pixel SHALL be accepted on a rising edge where px_valid and px_ready are both high.
REQ-005 px_ready SHALL be high only when the FIFO is not full, state is IDLE and no clear is pending; combinational from registered state only.
REQ-006 An accepted pixel with px_x >= SCR_W or px_y >= SCR_H SHALL be discarded, not stored, and drop_count incremented, saturating at 255.
REQ-007 States SHALL be IDLE, DRAIN (clear pending, FIFO non-empty), CLEAR.
REQ-008 In IDLE or DRAIN, at an edge with FIFO non-empty and mem_busy low, the head entry SHALL be popped and fb_addr = py*SCR_W + px, fb_data = colour, fb_wren = 1 registered; otherwise fb_wren = 0 next cycle.
REQ-009 Latency: a pixel accepted into an empty FIFO at edge N SHALL produce fb_wren high in the cycle after edge N+1 when mem_busy is low at edge N+1.
REQ-010 Writes SHALL leave in acceptance order; no entry lost or duplicated; mem_busy only stalls.
REQ-011 Address arithmetic SHALL be 15 bits unsigned; max address 19199.
REQ-012 clr_req in IDLE SHALL latch clr_color and assert clr_busy from the next cycle; FIFO empty -> CLEAR, else -> DRAIN.
REQ-013 DRAIN SHALL go to CLEAR on the edge that pops the last entry.
REQ-014 CLEAR SHALL write clr_color to addresses 0..SCR_W*SCR_H-1 in ascending order, one per edge with mem_busy low, holding the address while mem_busy is high.
REQ-015 After the write to address 19199, state SHALL return to IDLE and clr_busy SHALL drop in the same cycle fb_wren shows that final write.
REQ-016 clr_req while clr_busy is high SHALL be ignored.
REQ-017 clr_req and an accepted pixel in the same cycle: pixel SHALL be written before the clear.

Reset
REQ-018 reset SHALL asynchronously force state IDLE, FIFO empty, clear latch cleared, fb_wren 0, fb_addr 0, fb_data 0, clr_busy 0, drop_count 0; px_ready follows (high).
REQ-019 reset during DRAIN or CLEAR SHALL abort the operation; no further writes until new requests.

Structure
REQ-020 Package m_fb_pkg SHALL hold SCR_W, SCR_H, FB_SIZE (19200), FB_AW (15), colour width (12) and state encoding.
REQ-021 Pixel storage SHALL be sub-module m_px_fifo (synchronous FIFO, 27-bit entries {x,y,colour}, full/empty flags, async active-high reset).

Verification
REQ-022 Single pixel (10,5,h0F0), mem_busy 0 -> one fb_wren, fb_addr 810, fb_data h0F0, two cycles after acceptance.
REQ-023 Five back-to-back pixels with mem_busy held high -> px_ready low after 4 accepts; release mem_busy -> 4 writes then 5th, in order, no duplicates.
REQ-024 Pixels (160,0) and (0,120) plus 300 more out-of-range -> no fb_wren; drop_count = 255 final.
REQ-025 clr_req with clr_color h00F, mem_busy 0 -> 19200 consecutive writes, addresses 0..19199, then IDLE; mem_busy toggling 50% -> same sequence, no gaps.
REQ-026 Three pixels queued, mem_busy high, clr_req -> pixels written first, then clear; px_ready low until clr_busy drops.
REQ-027 reset at clear address 5000 -> fb_wren 0, clr_busy 0, px_ready 1 immediately; no further writes.
